button_debounce: RTL

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_pkg.sv | 18 +
 rtl/sync_2ff.sv | 29 ++
 rtl/button_debounce.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types and constants for the button debouncer.
// Contents:
//   btn_state_t                 - debounce FSM state encoding
//   DefaultDebounceCycles       - 10 ms at 200 MHz
//   DefaultLongPressCycles      - 1 s at 200 MHz
package button_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPressing,
    StHeld,
    StReleasing
  } btn_state_t;

  localparam int unsigned DefaultDebounceCycles  = 2_000_000;
  localparam int unsigned DefaultLongPressCycles = 200_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clk - sampling clock
//   rst - synchronous active-high reset, clears both flops
//   d   - asynchronous input
//   q   - synchronized output, two clk cycles behind d
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer with press/release pulses, a toggle output and an
// optional long-press event.
// Ports:
//   clk           - sole clock
//   rst           - synchronous active-high reset
//   button        - raw asynchronous button pin
//   pressed       - debounced level, 1 = pressed
//   press_pulse   - one-cycle pulse on an accepted press
//   release_pulse - one-cycle pulse on an accepted release
//   toggle        - inverts on every accepted press
//   long_pulse    - one-cycle pulse once the press has been held long enough
// Build option:
//   BUTTON_DEBOUNCE_LONG_PRESS_EN - when defined, builds the hold counter and
//   long_pulse; otherwise long_pulse is tied low and LONG_PRESS_CYCLES is unused.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DefaultDebounceCycles,
  parameter int unsigned LONG_PRESS_CYCLES = DefaultLongPressCycles,
  parameter bit          ACTIVE_LOW        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic toggle,
  output logic long_pulse
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  // The cycle spent in IDLE/HELD that sees the new level is the first stable
  // sample, so the counter only has to cover the remaining cycles.
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 2);

  logic       btn_s;
  btn_state_t state_q;
  logic [DbW-1:0] db_cnt_q;
  logic       pressed_q;
  logic       press_pulse_q;
  logic       release_pulse_q;
  logic       toggle_q;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button ^ ACTIVE_LOW),
    .q   (btn_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      db_cnt_q        <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      toggle_q        <= 1'b0;
    end else begin
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (btn_s) begin
            state_q  <= StPressing;
            db_cnt_q <= '0;
          end
        end
        StPressing: begin
          if (!btn_s) begin
            state_q  <= StIdle;
            db_cnt_q <= '0;
          end else if (db_cnt_q >= DbLast) begin
            state_q       <= StHeld;
            db_cnt_q      <= '0;
            pressed_q     <= 1'b1;
            press_pulse_q <= 1'b1;
            toggle_q      <= ~toggle_q;
          end else begin
            // Bounded by the compare above, so it never wraps.
            db_cnt_q <= db_cnt_q + DbW'(1);
          end
        end
        StHeld: begin
          if (!btn_s) begin
            state_q  <= StReleasing;
            db_cnt_q <= '0;
          end
        end
        StReleasing: begin
          if (btn_s) begin
            state_q  <= StHeld;
            db_cnt_q <= '0;
          end else if (db_cnt_q >= DbLast) begin
            state_q         <= StIdle;
            db_cnt_q        <= '0;
            pressed_q       <= 1'b0;
            release_pulse_q <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + DbW'(1);
          end
        end
        default: begin
          state_q  <= StIdle;
          db_cnt_q <= '0;
        end
      endcase
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign toggle        = toggle_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned HoldW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_PRESS_CYCLES);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_PRESS_CYCLES - 1);

  logic [HoldW-1:0] hold_cnt_q;
  logic             long_done_q;
  logic             long_pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q   <= '0;
      long_done_q  <= 1'b0;
      long_pulse_q <= 1'b0;
    end else begin
      long_pulse_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          hold_cnt_q  <= '0;
          long_done_q <= 1'b0;
        end
        StPressing: begin
          // Guarantees HELD is entered with a zero hold count.
          hold_cnt_q <= '0;
        end
        StHeld: begin
          if (btn_s) begin
            if (hold_cnt_q != HoldMax) begin
              hold_cnt_q <= hold_cnt_q + HoldW'(1);
            end
            if (hold_cnt_q == HoldLast && !long_done_q) begin
              long_pulse_q <= 1'b1;
              long_done_q  <= 1'b1;
            end
          end
        end
        StReleasing: begin
          // A rejected release glitch resumes the same press; keep the count.
          hold_cnt_q <= hold_cnt_q;
        end
        default: begin
          hold_cnt_q <= '0;
        end
      endcase
    end
  end

  assign long_pulse = long_pulse_q;
`else
  assign long_pulse = 1'b0;
`endif

endmodule
